spike_window_classifier: RTL

- Sits directly downstream of the neuron layer and consumes its N-bit output_spikes vector.
- Accumulates per-neuron spike counts over a programmable window of enabled timesteps.
- Then scans the counts sequentially and reports the winning neuron index (class), its count, and a tie flag.
- Provides the chip's classification result and a start/busy/valid handshake to the controller.

---
 rtl/snn_pkg.sv | 14 +
 rtl/spike_counter_sat.sv | 17 +
 rtl/spike_window_classifier.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the spike window classifier.
package snn_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEF   = 4;
  localparam int CW_DEF  = 6;
  localparam int IW_DEF  = 2;
  localparam int CNT_MAX = (1 << CW_DEF) - 1;
endpackage

// File: rtl/spike_counter_sat.sv
// Single saturating spike counter with synchronous clear.
module spike_counter_sat #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);
  // Clear wins over increment; hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + CW'(1);
  end
endmodule

// File: rtl/spike_window_classifier.sv
// Counts spikes per neuron over a window of enabled timesteps, then scans the
// counts one neuron per clock to pick the winner (lowest index on ties).
module spike_window_classifier
  import snn_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [N-1:0]  input_spikes,
  input  logic          start,
  input  logic [7:0]    window_length,
  output logic          busy,
  output logic          result_valid,
  output logic [IW-1:0] winner,
  output logic [CW-1:0] winner_count,
  output logic          tie
);
  state_t               state;
  logic [7:0]           win_len;
  logic [7:0]           ts;
  logic [IW-1:0]        scan_idx;
  logic [CW-1:0]        best;
  logic [IW-1:0]        best_idx;
  logic                 tie_acc;
  logic [N-1:0][CW-1:0] counts;
  logic                 clr;
  logic [N-1:0]         inc;

  // Counters clear on an accepted start so a new window never inherits counts.
  assign clr = (state == IDLE) && start;

  for (genvar i = 0; i < N; i++) begin : g_cnt
    assign inc[i] = (state == COUNT) && enable && input_spikes[i];
    spike_counter_sat #(.CW(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (inc[i]),
      .count (counts[i])
    );
  end

  logic [CW-1:0] cur;
  logic [CW-1:0] nxt_best;
  logic [IW-1:0] nxt_idx;
  logic          nxt_tie;
  logic          scan_last;

  // One argmax step: idx 0 seeds, strict > keeps the lowest index on ties.
  always_comb begin
    cur       = counts[scan_idx];
    nxt_best  = best;
    nxt_idx   = best_idx;
    nxt_tie   = tie_acc;
    scan_last = (scan_idx == IW'(N - 1));
    if (scan_idx == '0) begin
      nxt_best = cur;
      nxt_idx  = '0;
      nxt_tie  = 1'b0;
    end else if (cur > best) begin
      nxt_best = cur;
      nxt_idx  = scan_idx;
      nxt_tie  = 1'b0;
    end else if (cur == best) begin
      nxt_tie  = 1'b1;
    end
  end

  // Control FSM; results are written on the edge into DONE so they appear
  // together with the result_valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      win_len      <= 8'd1;
      ts           <= '0;
      scan_idx     <= '0;
      best         <= '0;
      best_idx     <= '0;
      tie_acc      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win_len <= (window_length == 8'd0) ? 8'd1 : window_length;
            ts      <= '0;
            busy    <= 1'b1;
            state   <= COUNT;
          end
        end
        COUNT: begin
          if (enable) begin
            ts <= ts + 8'd1;
            if ((ts + 8'd1) == win_len) begin
              scan_idx <= '0;
              state    <= SCAN;
            end
          end
        end
        SCAN: begin
          best     <= nxt_best;
          best_idx <= nxt_idx;
          tie_acc  <= nxt_tie;
          scan_idx <= scan_idx + IW'(1);
          if (scan_last) begin
            winner       <= nxt_idx;
            winner_count <= nxt_best;
            tie          <= nxt_tie;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
